// File: rtl/axis_noc_packetizer_if.sv
// AXI-Stream bundle used on both sides of the NoC packetizer.
interface axis_noc_packetizer_if #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_noc_packetizer.sv
// Buffers a user AXI-Stream and splits long user packets into NoC packets of
// at most MAX_PACKET_BEATS beats, holding tdest/tid across continuations.
module axis_noc_packetizer #(
  parameter int unsigned TDATA_WIDTH      = 32,
  parameter int unsigned TDEST_WIDTH      = 4,
  parameter int unsigned TID_WIDTH        = 2,
  parameter int unsigned BUFFER_DEPTH     = 4,
  parameter int unsigned MAX_PACKET_BEATS = 8,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                  clk_usr,
  input  logic                  rst_n,
  axis_noc_packetizer_if.slave  s_axis,
  axis_noc_packetizer_if.master m_axis,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  split_count
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned BW = $clog2(MAX_PACKET_BEATS) + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [TDATA_WIDTH-1:0] mem_data [BUFFER_DEPTH];
  logic                   mem_last [BUFFER_DEPTH];
  logic [TID_WIDTH-1:0]   mem_id   [BUFFER_DEPTH];
  logic [TDEST_WIDTH-1:0] mem_dest [BUFFER_DEPTH];

  logic [AW:0]            wr_ptr, rd_ptr;
  state_t                 state;
  logic [BW-1:0]          beat_cnt;
  logic [TDEST_WIDTH-1:0] lat_dest;
  logic [TID_WIDTH-1:0]   lat_id;

  logic                   empty, full, push, pop, s_ready;
  logic                   head_last, cnt_hit, out_last;
  logic [TDATA_WIDTH-1:0] head_data;
  logic [TID_WIDTH-1:0]   head_id;
  logic [TDEST_WIDTH-1:0] head_dest;

  // FIFO status, handshakes and head-of-queue view
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    s_ready   = rst_n & ~full;
    push      = s_axis.tvalid & s_ready;
    pop       = ~empty & m_axis.tready;
    head_data = mem_data[rd_ptr[AW-1:0]];
    head_last = mem_last[rd_ptr[AW-1:0]];
    head_id   = mem_id[rd_ptr[AW-1:0]];
    head_dest = mem_dest[rd_ptr[AW-1:0]];
    cnt_hit   = (beat_cnt == BW'(MAX_PACKET_BEATS - 1));
    out_last  = ~empty & (head_last | cnt_hit);
  end

  // Output side: empty FIFO presents zeros; ACTIVE replays the latched route
  always_comb begin
    s_axis.tready = s_ready;
    m_axis.tvalid = ~empty;
    m_axis.tlast  = out_last;
    m_axis.tdata  = empty ? '0 : head_data;
    if (state == ACTIVE) begin
      m_axis.tid   = lat_id;
      m_axis.tdest = lat_dest;
    end else begin
      m_axis.tid   = empty ? '0 : head_id;
      m_axis.tdest = empty ? '0 : head_dest;
    end
  end

  // FIFO storage write; contents need no reset because empty masks them
  always_ff @(posedge clk_usr) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= s_axis.tdata;
      mem_last[wr_ptr[AW-1:0]] <= s_axis.tlast;
      mem_id[wr_ptr[AW-1:0]]   <= s_axis.tid;
      mem_dest[wr_ptr[AW-1:0]] <= s_axis.tdest;
    end
  end

  // Pointers, packet state machine, beat counter and statistics
  always_ff @(posedge clk_usr) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      beat_cnt    <= '0;
      lat_dest    <= '0;
      lat_id      <= '0;
      pkt_count   <= '0;
      split_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        // A forced split keeps ACTIVE so the continuation reuses dest/id
        case (state)
          IDLE: if (!head_last) begin
            state    <= ACTIVE;
            lat_dest <= head_dest;
            lat_id   <= head_id;
          end
          ACTIVE: if (head_last) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (out_last) begin
          beat_cnt  <= '0;
          pkt_count <= pkt_count + 1'b1;
          if (!head_last) split_count <= split_count + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_noc_packetizer.sv
// Directed, table-driven bench for axis_noc_packetizer.
module tb_axis_noc_packetizer;

  localparam int unsigned DW = 32;
  localparam int unsigned DSW = 4;
  localparam int unsigned IW = 2;

  logic        clk_usr = 1'b0;
  logic        rst_n;
  logic [15:0] pkt_count, split_count;

  always #5 clk_usr = ~clk_usr;

  axis_noc_packetizer_if #(.TDATA_WIDTH(DW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW)) s_if ();
  axis_noc_packetizer_if #(.TDATA_WIDTH(DW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW)) m_if ();

  axis_noc_packetizer #(
    .TDATA_WIDTH(DW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW),
    .BUFFER_DEPTH(4), .MAX_PACKET_BEATS(8), .CNT_WIDTH(16)
  ) dut (
    .clk_usr(clk_usr), .rst_n(rst_n),
    .s_axis(s_if), .m_axis(m_if),
    .pkt_count(pkt_count), .split_count(split_count)
  );

  typedef struct {
    int          n;
    logic [3:0]  dest;
    logic [1:0]  id;
    bit          tog;
    logic [31:0] last_mask;
    int          exp_pkt;
    int          exp_split;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
    logic [1:0]  id;
    int          cyc;
  } beat_t;

  vec_t  vecs [11];
  beat_t outq [$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    accepted = 0;

  always @(posedge clk_usr) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle; inputs only change just after posedge
  always @(negedge clk_usr) begin
    if (rst_n === 1'b1) begin
      if (m_if.tvalid && m_if.tready)
        outq.push_back('{m_if.tdata, m_if.tlast, m_if.tdest, m_if.tid, cyc});
      if (s_if.tvalid && s_if.tready) accepted++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input int v, input int b);
    return {8'hD0, 8'(v), 16'(b)};
  endfunction

  task automatic send_range(input int v, input int b0, input int b1);
    for (int b = b0; b <= b1; b++) begin
      int w = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = beat_data(v, b);
      s_if.tlast  = (b == vecs[v].n - 1);
      s_if.tdest  = (vecs[v].tog && b > 0) ? ~vecs[v].dest : vecs[v].dest;
      s_if.tid    = (vecs[v].tog && b > 0) ? ~vecs[v].id : vecs[v].id;
      @(negedge clk_usr);
      while (!s_if.tready && w < 200) begin
        @(negedge clk_usr);
        w++;
      end
      if (w >= 200) begin
        chk($sformatf("v%0d_src_timeout", v), 64'(w), 64'(0));
        break;
      end
      @(posedge clk_usr);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    do begin
      @(posedge clk_usr);
      w++;
    end while (outq.size() < n && w < 300);
    #1;
    if (outq.size() < n) chk("out_timeout", 64'(outq.size()), 64'(n));
  endtask

  task automatic check_beats(input int v);
    beat_t bt;
    for (int b = 0; b < vecs[v].n; b++) begin
      if (outq.size() == 0) begin
        chk($sformatf("v%0d_b%0d_missing", v, b), 64'(0), 64'(1));
        break;
      end
      bt = outq.pop_front();
      chk($sformatf("v%0d_b%0d_data", v, b), 64'(bt.data), 64'(beat_data(v, b)));
      chk($sformatf("v%0d_b%0d_last", v, b), 64'(bt.last), 64'(vecs[v].last_mask[b]));
      chk($sformatf("v%0d_b%0d_dest", v, b), 64'(bt.dest), 64'(vecs[v].dest));
      chk($sformatf("v%0d_b%0d_id", v, b), 64'(bt.id), 64'(vecs[v].id));
    end
  endtask

  task automatic check_counts(input int v);
    chk($sformatf("v%0d_pkt_count", v), 64'(pkt_count), 64'(vecs[v].exp_pkt));
    chk($sformatf("v%0d_split_count", v), 64'(split_count), 64'(vecs[v].exp_split));
  endtask

  initial begin
    beat_t bt;
    int    prev;

    //          n   dest   id  tog  last mask       pkt split
    vecs[0]  = '{3,  4'd5,  2'd1, 0, 32'h0000_0004,  1, 0};
    vecs[1]  = '{20, 4'd9,  2'd2, 1, 32'h0008_8080,  4, 2};
    vecs[2]  = '{8,  4'd3,  2'd0, 0, 32'h0000_0080,  5, 2};
    vecs[3]  = '{3,  4'd12, 2'd3, 1, 32'h0000_0004,  6, 2};
    vecs[4]  = '{1,  4'd0,  2'd0, 0, 32'h0000_0001,  2, 0};
    vecs[5]  = '{1,  4'd1,  2'd1, 0, 32'h0000_0001,  3, 0};
    vecs[6]  = '{1,  4'd2,  2'd2, 0, 32'h0000_0001,  4, 0};
    vecs[7]  = '{1,  4'd3,  2'd3, 0, 32'h0000_0001,  5, 0};
    vecs[8]  = '{6,  4'd6,  2'd1, 0, 32'h0000_0020,  7, 2};
    vecs[9]  = '{6,  4'd7,  2'd3, 0, 32'h0000_0000,  0, 0};
    vecs[10] = '{1,  4'd2,  2'd0, 0, 32'h0000_0001,  1, 0};

    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk_usr);
    #1;
    chk("rst_s_tready_low", 64'(s_if.tready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk_usr);
    #1;
    chk("rst_s_tready", 64'(s_if.tready), 64'(1));
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    chk("rst_m_tdata", 64'(m_if.tdata), 64'(0));
    chk("rst_m_tdest", 64'(m_if.tdest), 64'(0));
    chk("rst_m_tid", 64'(m_if.tid), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_split_count", 64'(split_count), 64'(0));

    // Single packets: short, split with toggled non-head routing, exact MAX, next head
    for (int v = 0; v < 4; v++) begin
      send_range(v, 0, vecs[v].n - 1);
      wait_out(vecs[v].n);
      check_beats(v);
      check_counts(v);
    end

    // Back-pressure: FIFO fills to four beats and stays stable
    m_if.tready = 1'b0;
    accepted    = 0;
    fork
      send_range(8, 0, vecs[8].n - 1);
    join_none
    repeat (10) @(posedge clk_usr);
    #1;
    chk("stall_s_tready", 64'(s_if.tready), 64'(0));
    chk("stall_accepted", 64'(accepted), 64'(4));
    chk("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
    chk("stall_head_data", 64'(m_if.tdata), 64'(beat_data(8, 0)));
    chk("stall_out_none", 64'(outq.size()), 64'(0));
    m_if.tready = 1'b1;
    wait fork;
    wait_out(vecs[8].n);
    check_beats(8);
    check_counts(8);
    chk("stall_accepted_all", 64'(accepted), 64'(6));

    // Reset mid-packet: three beats delivered, two buffered, then reset
    send_range(9, 0, 2);
    repeat (3) @(posedge clk_usr);
    #1;
    chk("mid_pre_out", 64'(outq.size()), 64'(3));
    outq.delete();
    m_if.tready = 1'b0;
    send_range(9, 3, 4);
    chk("mid_buffered_valid", 64'(m_if.tvalid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk_usr);
    chk("mid_rst_s_tready", 64'(s_if.tready), 64'(0));
    @(posedge clk_usr);
    #1;
    chk("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("mid_rst_m_tlast", 64'(m_if.tlast), 64'(0));
    chk("mid_rst_m_tdest", 64'(m_if.tdest), 64'(0));
    check_counts(9);
    rst_n       = 1'b1;
    m_if.tready = 1'b1;
    send_range(10, 0, 0);
    wait_out(1);
    check_beats(10);
    check_counts(10);
    repeat (4) @(posedge clk_usr);
    #1;
    chk("mid_no_leftover", 64'(outq.size()), 64'(0));

    // Back-to-back single-beat packets, one per cycle
    for (int v = 4; v < 8; v++) send_range(v, 0, 0);
    wait_out(4);
    prev = -1;
    for (int v = 4; v < 8; v++) begin
      if (outq.size() == 0) break;
      bt = outq[0];
      if (prev >= 0) chk($sformatf("b2b_v%0d_gap", v), 64'(bt.cyc - prev), 64'(1));
      prev = bt.cyc;
      check_beats(v);
    end
    check_counts(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
